// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte producers
module uart_tx_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ID_WIDTH    = $clog2(NUM_CLIENTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLIENTS-1:0]          req_valid,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_CLIENTS-1:0]          req_ready,
    input  logic [NUM_CLIENTS-1:0]          client_en,
    output logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic                            busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, GUARD, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;
    logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]     last_q, last_d;

    logic [NUM_CLIENTS-1:0]  elig;
    logic                    any_elig;
    logic                    grant_ok;
    logic                    hi_found;
    logic [ID_WIDTH-1:0]     hi_winner, lo_winner, winner;
    logic [DATA_WIDTH-1:0]   hi_word, lo_word, win_word;

    // Clients above last win over clients at or below it; the lowest index wins in each half.
    always_comb begin
        elig      = req_valid & client_en;
        any_elig  = |elig;
        hi_found  = 1'b0;
        hi_winner = '0;
        lo_winner = '0;
        hi_word   = '0;
        lo_word   = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (elig[i] && (i > int'(last_q))) begin
                hi_found  = 1'b1;
                hi_winner = ID_WIDTH'(i);
                hi_word   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (elig[i] && (i <= int'(last_q))) begin
                lo_winner = ID_WIDTH'(i);
                lo_word   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        winner   = hi_found ? hi_winner : lo_winner;
        win_word = hi_found ? hi_word : lo_word;
    end

    assign grant_ok = !rst && (state_q == IDLE) && tx_ready && any_elig;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_ok && (winner == ID_WIDTH'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    tx_data_d  = win_word;
                    grant_id_d = winner;
                    last_d     = winner;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (tx_ready) begin
                    state_d = GUARD;
                end
            end
            // One cycle blind to tx_ready while the transmitter's registered ready falls.
            GUARD:   state_d = BUSY;
            BUSY: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_valid_d = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            last_q     <= ID_WIDTH'(NUM_CLIENTS - 1);
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     client_en;
    logic [W-1:0]     tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [IW-1:0]    grant_id;
    logic             busy;

    int               checks = 0;
    int               errors = 0;
    exp_t             sb[$];
    exp_t             e;
    bit               auto_tx = 1'b0;
    logic             man_ready = 1'b1;
    logic             model_ready = 1'b1;
    int               frame_cnt = 0;
    bit               hs_neg = 1'b0;
    logic [N-1:0]     forbid_mask = '0;
    logic             prev_valid = 1'b0;
    logic [W-1:0]     prev_data = '0;

    uart_tx_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(W), .ID_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .client_en (client_en),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign tx_ready = auto_tx ? model_ready : man_ready;

    // Transmitter model: ready drops for a frame after each accepted word
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            model_ready = 1'b1;
            frame_cnt   = 0;
        end else if (hs_neg) begin
            model_ready = 1'b0;
            frame_cnt   = 5;
        end else if (frame_cnt > 0) begin
            frame_cnt = frame_cnt - 1;
            if (frame_cnt == 0) model_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        hs_neg = !rst && tx_valid && tx_ready;
        if (!rst) begin
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++;
                $display("FAIL onehot: req_ready=%b required at most one bit", req_ready);
            end
            checks++;
            if ((req_ready & forbid_mask) != '0) begin
                errors++;
                $display("FAIL disabled_grant: req_ready=%b forbidden=%b", req_ready, forbid_mask);
            end
            if (prev_valid && tx_valid) begin
                checks++;
                if (tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL data_stable: tx_data=%h required %h", tx_data, prev_data);
                end
            end
            if (hs_neg) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx: id=%0d data=%h with empty scoreboard", grant_id, tx_data);
                end else begin
                    e = sb.pop_front();
                    if (tx_data !== e.data || grant_id !== e.id) begin
                        errors++;
                        $display("FAIL tx_word: got id=%0d data=%h required id=%0d data=%h",
                                 grant_id, tx_data, e.id, e.data);
                    end
                end
            end
        end
        prev_valid = !rst && tx_valid;
        prev_data  = tx_data;
    end

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 5;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: %b required 0", tx_valid); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: %h required 00", tx_data); end
        if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready: %b required 0000", req_ready); end
        if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: %0d required 0", grant_id); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b required 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        auto_tx = 1'b0;
        man_ready = 1'b1;
        sb.push_back('{2'd0, 8'hA5});
        @(posedge clk);
        #1;
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready: %b required 0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks += 4;
        if (req_ready !== 4'b0) begin errors++; $display("FAIL single_pulse: %b required 0000", req_ready); end
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL single_tx: valid=%b data=%h required 1 a5", tx_valid, tx_data);
        end
        if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant_id: %0d required 0", grant_id); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: %b required 1", busy); end
        @(posedge clk);
        #1;
        man_ready = 1'b0;
        req_data[15:8] = 8'h5A;
        req_valid = 4'b0010;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || req_ready !== 4'b0 || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_hold: cycle %0d busy=%b req_ready=%b tx_valid=%b required 1 0000 0",
                         c, busy, req_ready, tx_valid);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        man_ready = 1'b1;
        wait_idle(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_contend();
        bit ok;
        auto_tx = 1'b1;
        sb.push_back('{2'd1, 8'h11});
        sb.push_back('{2'd2, 8'h22});
        sb.push_back('{2'd1, 8'h11});
        sb.push_back('{2'd2, 8'h22});
        @(posedge clk);
        #1;
        req_data[15:8]  = 8'h11;
        req_data[23:16] = 8'h22;
        req_valid = 4'b0110;
        wait_drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL contend_drain: %0d words left required 0", sb.size()); end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_idle(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL contend_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_mask();
        bit ok;
        auto_tx = 1'b1;
        client_en = 4'b1010;
        forbid_mask = 4'b0101;
        sb.push_back('{2'd3, 8'hC3});
        sb.push_back('{2'd1, 8'hC1});
        sb.push_back('{2'd3, 8'hC3});
        sb.push_back('{2'd1, 8'hC1});
        @(posedge clk);
        #1;
        req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        req_valid = 4'b1111;
        wait_drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mask_drain: %0d words left required 0", sb.size()); end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_idle(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mask_idle: busy=%b required 0", busy); end
        client_en = 4'b1111;
        forbid_mask = 4'b0000;
    endtask

    task automatic test_tx_not_ready();
        bit ok;
        auto_tx = 1'b0;
        man_ready = 1'b0;
        sb.push_back('{2'd2, 8'h77});
        @(posedge clk);
        #1;
        req_data[23:16] = 8'h77;
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0 || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL notready_wait: req_ready=%b tx_valid=%b required 0000 0", req_ready, tx_valid);
            end
        end
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL notready_grant: %b required 0100", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
            errors++; $display("FAIL notready_tx: valid=%b data=%h required 1 77", tx_valid, tx_data);
        end
        wait_idle(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL notready_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        auto_tx = 1'b1;
        sb.push_back('{2'd0, 8'h31});
        @(posedge clk);
        #1;
        req_data[7:0] = 8'h31;
        req_valid = 4'b0001;
        wait_drain(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_drain: %0d words left required 0", sb.size()); end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: %b required 1", busy); end
        rst = 1'b1;
        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        req_valid = 4'b1111;
        #1;
        checks += 4;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid: %b required 0", tx_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: %b required 0", busy); end
        if (req_ready !== 4'b0) begin errors++; $display("FAIL rstmid_req_ready: %b required 0000", req_ready); end
        if (grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_grant_id: %0d required 0", grant_id); end
        for (int i = 0; i < N; i++) begin
            sb.push_back('{IW'(i), 8'hD0 + 8'(i)});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_order: %0d words left required 0", sb.size()); end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_idle(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_late_drop();
        bit ok;
        auto_tx = 1'b0;
        man_ready = 1'b1;
        sb.push_back('{2'd3, 8'h3C});
        @(posedge clk);
        #1;
        req_data[31:24] = 8'h3C;
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL late_req_ready: %b required 1000", req_ready); end
        @(posedge clk);
        #1;
        man_ready = 1'b0;
        req_valid = 4'b0000;
        req_data[31:24] = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
                errors++; $display("FAIL late_hold: valid=%b data=%h required 1 3c", tx_valid, tx_data);
            end
        end
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        wait_idle(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL late_idle: busy=%b required 0", busy); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL late_regrant: req_ready=%b busy=%b required 0000 0", req_ready, busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        client_en = '1;
        test_reset();
        test_single();
        test_contend();
        test_mask();
        test_tx_not_ready();
        test_reset_mid();
        test_late_drop();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d words left required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
